// File: rtl/commit_checker.sv
// Lockstep commit checker: buffers expected retirement records in a FIFO and compares each DUT retirement against the head.
// Optional first-failure data/cause capture is enabled by defining COMMIT_CHECKER_CAPTURE_EN.
module commit_checker #(
  parameter int p_WIDTH      = 16,
  parameter int p_NUM_REGS   = 8,
  parameter int p_FIFO_DEPTH = 4,
  parameter int p_COUNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stop_on_fail,
  input  logic                          exp_valid,
  output logic                          exp_ready,
  input  logic [p_WIDTH-1:0]            exp_pc,
  input  logic                          exp_we,
  input  logic [$clog2(p_NUM_REGS)-1:0] exp_rd,
  input  logic [p_WIDTH-1:0]            exp_wdata,
  input  logic                          dut_valid,
  input  logic [p_WIDTH-1:0]            dut_pc,
  input  logic                          dut_we,
  input  logic [$clog2(p_NUM_REGS)-1:0] dut_rd,
  input  logic [p_WIDTH-1:0]            dut_wdata,
  output logic [p_COUNT_W-1:0]          checked_count,
  output logic [p_COUNT_W-1:0]          fail_count,
  output logic                          mismatch,
  output logic                          underflow,
  output logic                          first_fail_valid,
  output logic [p_COUNT_W-1:0]          first_fail_index,
  output logic [p_WIDTH-1:0]            first_fail_pc,
`ifdef COMMIT_CHECKER_CAPTURE_EN
  output logic [p_WIDTH-1:0]            first_fail_exp_wdata,
  output logic [p_WIDTH-1:0]            first_fail_dut_wdata,
  output logic [2:0]                    first_fail_cause,
`endif
  output logic                          halted
);

  localparam int RD_W = $clog2(p_NUM_REGS);
  localparam int AW   = $clog2(p_FIFO_DEPTH);

  localparam logic [AW:0]          PTR_ONE = 1;
  localparam logic [p_COUNT_W-1:0] CNT_ONE = 1;

  typedef struct packed {
    logic [p_WIDTH-1:0] pc;
    logic               we;
    logic [RD_W-1:0]    rd;
    logic [p_WIDTH-1:0] wdata;
  } rec_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   run;

  rec_t        mem [p_FIFO_DEPTH];
  rec_t        head;
  rec_t        push_rec;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;

  logic pc_diff, ctl_diff, data_diff, rec_fail;
  logic compare, orphan, fail;

  // ---------------------------------------------------------------- FIFO
  // The extra pointer MSB distinguishes full (MSBs differ) from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign exp_ready = !full && run;
  assign push      = exp_valid && exp_ready;
  assign pop       = compare;

  assign push_rec = '{pc: exp_pc, we: exp_we, rd: exp_rd, wdata: exp_wdata};
  assign head     = mem[rd_ptr[AW-1:0]];

  // NOTE: the record storage has no reset; empty/full come from the pointers,
  // so stale entries are never observed and the array can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_rec;
  end

  // NOTE: all state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------- compare
  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    pc_diff   = (head.pc != dut_pc);
    ctl_diff  = (head.we != dut_we) || (head.we && dut_we && (head.rd != dut_rd));
    // r0 is hardwired zero, so its write data is never meaningful.
    data_diff = head.we && dut_we && (head.rd != '0) && (head.wdata != dut_wdata);
    rec_fail  = pc_diff || ctl_diff || data_diff;
  end

  assign compare = run && dut_valid && !empty;
  assign orphan  = run && dut_valid && empty;
  assign fail    = (compare && rec_fail) || orphan;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (fail && stop_on_fail) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    run    = (state == RUN);
    halted = (state == HALT);
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checked_count <= '0;
      fail_count    <= '0;
      mismatch      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      if (compare && (checked_count != '1)) checked_count <= checked_count + CNT_ONE;
      if (fail && (fail_count != '1))       fail_count    <= fail_count + CNT_ONE;
      mismatch <= fail;
      if (orphan) underflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- first-failure capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail_valid <= 1'b0;
      first_fail_index <= '0;
      first_fail_pc    <= '0;
    end else if (fail && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_index <= checked_count;
      first_fail_pc    <= dut_pc;
    end
  end

`ifdef COMMIT_CHECKER_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail_exp_wdata <= '0;
      first_fail_dut_wdata <= '0;
      first_fail_cause     <= '0;
    end else if (fail && !first_fail_valid) begin
      first_fail_dut_wdata <= dut_wdata;
      // An orphan has no expected record behind it.
      if (orphan) begin
        first_fail_exp_wdata <= '0;
        first_fail_cause     <= 3'b000;
      end else begin
        first_fail_exp_wdata <= head.wdata;
        first_fail_cause     <= {pc_diff, ctl_diff, data_diff};
      end
    end
  end
`endif

endmodule

// File: tb/tb_commit_checker.sv
// Self-checking bench for commit_checker: directed scenarios plus randomized traffic against a queue-based model.
module tb_commit_checker;

  localparam int W    = 16;
  localparam int NR   = 8;
  localparam int D    = 4;
  localparam int CW   = 16;
  localparam int RW   = 3;
  localparam int CMAX = 65535;

  typedef struct {
    logic [W-1:0]  pc;
    logic          we;
    logic [RW-1:0] rd;
    logic [W-1:0]  wdata;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stop_on_fail = 1'b0;
  logic          exp_valid = 1'b0;
  logic          exp_ready;
  logic [W-1:0]  exp_pc = '0;
  logic          exp_we = 1'b0;
  logic [RW-1:0] exp_rd = '0;
  logic [W-1:0]  exp_wdata = '0;
  logic          dut_valid = 1'b0;
  logic [W-1:0]  dut_pc = '0;
  logic          dut_we = 1'b0;
  logic [RW-1:0] dut_rd = '0;
  logic [W-1:0]  dut_wdata = '0;
  logic [CW-1:0] checked_count, fail_count, first_fail_index;
  logic          mismatch, underflow, first_fail_valid, halted;
  logic [W-1:0]  first_fail_pc;
`ifdef COMMIT_CHECKER_CAPTURE_EN
  logic [W-1:0]  first_fail_exp_wdata, first_fail_dut_wdata;
  logic [2:0]    first_fail_cause;
`endif

  always #5 clk = ~clk;

  commit_checker #(
    .p_WIDTH(W), .p_NUM_REGS(NR), .p_FIFO_DEPTH(D), .p_COUNT_W(CW)
  ) u_dut (
    .clk(clk), .rst(rst), .stop_on_fail(stop_on_fail),
    .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_pc(exp_pc), .exp_we(exp_we), .exp_rd(exp_rd), .exp_wdata(exp_wdata),
    .dut_valid(dut_valid),
    .dut_pc(dut_pc), .dut_we(dut_we), .dut_rd(dut_rd), .dut_wdata(dut_wdata),
    .checked_count(checked_count), .fail_count(fail_count),
    .mismatch(mismatch), .underflow(underflow),
    .first_fail_valid(first_fail_valid), .first_fail_index(first_fail_index),
    .first_fail_pc(first_fail_pc),
`ifdef COMMIT_CHECKER_CAPTURE_EN
    .first_fail_exp_wdata(first_fail_exp_wdata),
    .first_fail_dut_wdata(first_fail_dut_wdata),
    .first_fail_cause(first_fail_cause),
`endif
    .halted(halted)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  rec_t        m_q[$];
  bit          m_halt, m_under, m_mis, m_ffv;
  int          m_chk, m_fail, m_ffi;
  logic [W-1:0] m_ffpc, m_fexp, m_fdut;
  logic [2:0]  m_cause;

  // Returns {pc, we/rd, data} differences; any set bit is a failure.
  function automatic logic [2:0] diff_cause(input rec_t e, input rec_t d);
    logic both_we;
    both_we = e.we && d.we;
    return {e.pc != d.pc,
            (e.we != d.we) || (both_we && e.rd != d.rd),
            both_we && e.rd != 0 && e.wdata != d.wdata};
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_halt = 0; m_under = 0; m_mis = 0; m_ffv = 0;
    m_chk = 0; m_fail = 0; m_ffi = 0;
    m_ffpc = '0; m_fexp = '0; m_fdut = '0; m_cause = '0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_checked"},  checked_count,    m_chk);
    check({pfx, "_fails"},    fail_count,       m_fail);
    check({pfx, "_mismatch"}, mismatch,         m_mis);
    check({pfx, "_underflow"},underflow,        m_under);
    check({pfx, "_ffv"},      first_fail_valid, m_ffv);
    check({pfx, "_ffi"},      first_fail_index, m_ffi);
    check({pfx, "_ffpc"},     first_fail_pc,    m_ffpc);
    check({pfx, "_halted"},   halted,           m_halt);
`ifdef COMMIT_CHECKER_CAPTURE_EN
    check({pfx, "_cause"},    first_fail_cause,     m_cause);
    check({pfx, "_ffexp"},    first_fail_exp_wdata, m_fexp);
    check({pfx, "_ffdut"},    first_fail_dut_wdata, m_fdut);
`endif
  endtask

  // One clock cycle: predict from the current inputs, clock, then compare.
  task automatic cycle();
    bit rdy, cmp, orph, bad;
    rec_t h, d;
    logic [2:0] cause;
    rdy = !m_halt && (m_q.size() < D);
    check("exp_ready", exp_ready, rdy);
    d = '{dut_pc, dut_we, dut_rd, dut_wdata};
    h = '{'0, 1'b0, '0, '0};
    cmp  = !m_halt && dut_valid && (m_q.size() != 0);
    orph = !m_halt && dut_valid && (m_q.size() == 0);
    cause = 3'b000;
    bad = orph;
    if (cmp) begin
      h = m_q[0];
      cause = diff_cause(h, d);
      bad = (cause != 3'b000);
    end
    @(posedge clk);
    #1;
    if (bad) begin
      if (!m_ffv) begin
        m_ffv = 1; m_ffi = m_chk; m_ffpc = d.pc;
        m_cause = cause; m_fexp = cmp ? h.wdata : '0; m_fdut = d.wdata;
      end
      if (m_fail < CMAX) m_fail++;
      if (orph) m_under = 1;
      if (stop_on_fail) m_halt = 1;
    end
    if (cmp) begin
      void'(m_q.pop_front());
      if (m_chk < CMAX) m_chk++;
    end
    if (exp_valid && rdy) m_q.push_back('{exp_pc, exp_we, exp_rd, exp_wdata});
    m_mis = bad;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_valid = 1'b0;
    dut_valid = 1'b0;
    #2;
    model_clear();
    check_outputs("rst");
    check("rst_exp_ready", exp_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_exp(input bit v, input logic [W-1:0] pc, input bit we,
                         input logic [RW-1:0] rd, input logic [W-1:0] wd);
    exp_valid = v; exp_pc = pc; exp_we = we; exp_rd = rd; exp_wdata = wd;
  endtask

  task automatic set_dut(input bit v, input logic [W-1:0] pc, input bit we,
                         input logic [RW-1:0] rd, input logic [W-1:0] wd);
    dut_valid = v; dut_pc = pc; dut_we = we; dut_rd = rd; dut_wdata = wd;
  endtask

  // Five records, the third carries a data error (expected BEEE, DUT BEEF).
  task automatic run_stream(input bit sof);
    logic [W-1:0] ewd, dwd;
    do_reset();
    stop_on_fail = sof;
    for (int i = 0; i <= 5; i++) begin
      ewd = (i + 1 == 3) ? 16'hBEEE : 16'h0100 + 16'(i + 1);
      set_exp(i < 5, 16'(i + 1), 1'b1, 3'd2, ewd);
      dwd = (i == 3) ? 16'hBEEF : 16'h0100 + 16'(i);
      set_dut(i >= 1, 16'(i), 1'b1, 3'd2, dwd);
      cycle();
    end
    set_exp(0, '0, 0, '0, '0);
    set_dut(0, '0, 0, '0, '0);
    cycle();
  endtask

  int mis_cycles;

  initial begin
    model_clear();
    do_reset();

    // Identical stream of four records.
    for (int i = 1; i <= 4; i++) begin
      set_exp(1, 16'(i), 1'b1, 3'd1, 16'h00AA + 16'(i - 1));
      cycle();
    end
    set_exp(0, '0, 0, '0, '0);
    for (int i = 1; i <= 4; i++) begin
      set_dut(1, 16'(i), 1'b1, 3'd1, 16'h00AA + 16'(i - 1));
      cycle();
    end
    set_dut(0, '0, 0, '0, '0);
    check("s1_checked", checked_count, 4);
    check("s1_fails", fail_count, 0);
    check("s1_empty_ready", exp_ready, 1'b1);

    // r0 write data is ignored.
    set_exp(1, 16'd5, 1'b1, 3'd0, 16'h1234);
    cycle();
    set_exp(0, '0, 0, '0, '0);
    set_dut(1, 16'd5, 1'b1, 3'd0, 16'h0000);
    cycle();
    set_dut(0, '0, 0, '0, '0);
    check("s2_fails", fail_count, 0);
    check("s2_checked", checked_count, 5);

    // Data mismatch, keep running.
    run_stream(1'b0);
    check("s3_fails", fail_count, 1);
    check("s3_ffi", first_fail_index, 2);
    check("s3_ffpc", first_fail_pc, 3);
    check("s3_checked", checked_count, 5);

    // Data mismatch, halt on first failure.
    run_stream(1'b1);
    check("s4_halted", halted, 1'b1);
    check("s4_checked", checked_count, 3);
    check("s4_ready", exp_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_exp(1, 16'h0040, 1'b0, '0, '0);
      set_dut(1, 16'h0077, 1'b1, 3'd3, 16'hDEAD);
      cycle();
    end
    check("s4_frozen_checked", checked_count, 3);
    check("s4_frozen_fails", fail_count, 1);
    do_reset();
    check("s4_rst_halted", halted, 1'b0);

    // Fill the FIFO, then stream through it across pointer wrap.
    for (int i = 0; i < 6; i++) begin
      set_exp(1, 16'h0200 + 16'(i), 1'b1, 3'(i), 16'h3000 + 16'(i));
      cycle();
    end
    check("s5_full_ready", exp_ready, 1'b0);
    for (int i = 0; i < 12; i++) begin
      set_exp(1, 16'h0300 + 16'(i), 1'b1, 3'(i + 1), 16'h4000 + 16'(i));
      set_dut(1, m_q[0].pc, m_q[0].we, m_q[0].rd, m_q[0].wdata);
      cycle();
    end
    set_exp(0, '0, 0, '0, '0);
    set_dut(0, '0, 0, '0, '0);
    check("s5_fails", fail_count, 0);

    // Orphan retirement with an empty FIFO.
    do_reset();
    set_dut(1, 16'h0055, 1'b0, '0, '0);
    cycle();
    set_dut(0, '0, 0, '0, '0);
    check("s6_underflow", underflow, 1'b1);
    check("s6_fails", fail_count, 1);
    check("s6_checked", checked_count, 0);
    check("s6_ffi", first_fail_index, 0);
`ifdef COMMIT_CHECKER_CAPTURE_EN
    check("s6_cause", first_fail_cause, 3'b000);
`endif
    cycle();
    check("s6_sticky", underflow, 1'b1);

    // Randomized traffic with occasional corruption and mid-run resets.
    do_reset();
    mis_cycles = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        stop_on_fail = ($urandom_range(0, 4) == 0);
      end
      set_exp($urandom_range(0, 99) < 55, 16'($urandom), 1'($urandom),
              3'($urandom), 16'($urandom));
      if (m_q.size() != 0) begin
        set_dut($urandom_range(0, 99) < 50, m_q[0].pc, m_q[0].we, m_q[0].rd, m_q[0].wdata);
        case ($urandom_range(0, 39))
          0: dut_pc    = dut_pc ^ 16'h0004;
          1: dut_we    = ~dut_we;
          2: dut_rd    = dut_rd + 3'd1;
          3: dut_wdata = dut_wdata ^ 16'h0100;
          default: ;
        endcase
      end else begin
        set_dut($urandom_range(0, 99) < 5, 16'($urandom), 1'($urandom),
                3'($urandom), 16'($urandom));
      end
      cycle();
      if (mismatch) mis_cycles++;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
